// File: rtl/saturn_bus_pkg.sv
// ---------------------------------------------------------------------------
// saturn_bus_pkg
// Shared definitions for the Saturn nibble-bus target: command codes, FSM
// state encoding, address geometry and small decode helpers.
// ---------------------------------------------------------------------------
package saturn_bus_pkg;

   localparam int ADDR_W       = 20;  // nibble address width
   localparam int ADDR_NIBBLES = 5;   // nibbles needed to assemble an address

   typedef enum logic [3:0] {
      CMD_NOP      = 4'h0,
      CMD_PC_READ  = 4'h2,
      CMD_DP_READ  = 4'h3,
      CMD_LOAD_PC  = 4'h4,
      CMD_LOAD_DP  = 4'h5,
      CMD_DP_WRITE = 4'h6,
      CMD_RESET    = 4'h8
   } cmd_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ_PC,
      ST_READ_DP,
      ST_LOAD_ADDR,
      ST_WRITE_DP
   } state_e;

   function automatic logic cmd_is_legal(input logic [3:0] code);
      logic legal;
      case (code)
         CMD_NOP, CMD_PC_READ, CMD_DP_READ, CMD_LOAD_PC,
         CMD_LOAD_DP, CMD_DP_WRITE, CMD_RESET: legal = 1'b1;
         default:                              legal = 1'b0;
      endcase
      return legal;
   endfunction

   // The next state depends only on the command code, never on the
   // state the command arrives in. Illegal codes fall back to idle.
   function automatic state_e cmd_next_state(input logic [3:0] code);
      state_e st;
      case (code)
         CMD_PC_READ:              st = ST_READ_PC;
         CMD_DP_READ:              st = ST_READ_DP;
         CMD_LOAD_PC, CMD_LOAD_DP: st = ST_LOAD_ADDR;
         CMD_DP_WRITE:             st = ST_WRITE_DP;
         default:                  st = ST_IDLE;
      endcase
      return st;
   endfunction

endpackage

// File: rtl/saturn_bus_target_if.sv
// ---------------------------------------------------------------------------
// saturn_bus_target_if
// Bundles the nibble bus, the memory port and the debug pointers of the
// Saturn bus target.
//   master modport : bus master / memory side (drives i_* signals)
//   slave  modport : saturn_bus_target (drives o_* signals)
// ---------------------------------------------------------------------------
interface saturn_bus_target_if;
   import saturn_bus_pkg::*;

   logic              i_bus_clk_en;
   logic              i_bus_is_data;
   logic [3:0]        i_bus_nibble;
   logic [3:0]        o_bus_nibble;
   logic [ADDR_W-1:0] o_mem_addr;
   logic              o_mem_we;
   logic [3:0]        o_mem_wdata;
   logic [3:0]        i_mem_rdata;
   logic              o_cmd_error;
   logic [ADDR_W-1:0] o_pc_ptr;
   logic [ADDR_W-1:0] o_dp_ptr;

   modport slave (
      input  i_bus_clk_en, i_bus_is_data, i_bus_nibble, i_mem_rdata,
      output o_bus_nibble, o_mem_addr, o_mem_we, o_mem_wdata,
             o_cmd_error, o_pc_ptr, o_dp_ptr
   );

   modport master (
      output i_bus_clk_en, i_bus_is_data, i_bus_nibble, i_mem_rdata,
      input  o_bus_nibble, o_mem_addr, o_mem_we, o_mem_wdata,
             o_cmd_error, o_pc_ptr, o_dp_ptr
   );

endinterface

// File: rtl/saturn_bus_addr_shift.sv
// ---------------------------------------------------------------------------
// saturn_bus_addr_shift
// Assembles a 20-bit address from 5 nibbles, least significant first.
// Ports:
//   i_clk, i_reset : clock, synchronous active-high reset
//   clear          : discard any partially assembled address
//   shift_en       : accept nibble this cycle
//   nibble         : incoming nibble
//   done           : high in the cycle the 5th nibble is accepted
//   value          : assembled address, valid while done is high
// ---------------------------------------------------------------------------
module saturn_bus_addr_shift
   import saturn_bus_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              clear,
   input  logic              shift_en,
   input  logic [3:0]        nibble,
   output logic              done,
   output logic [ADDR_W-1:0] value
);

   logic [ADDR_W-1:0] shift_reg;
   logic [2:0]        count_reg;

   // New nibbles enter the top lane and move down, so after five shifts
   // the first nibble received ends up in the least significant lane.
   genvar gi;
   generate
      for (gi = 0; gi < ADDR_NIBBLES; gi++) begin : g_lane
         always_ff @(posedge i_clk) begin
            if (i_reset) begin
               shift_reg[gi*4 +: 4] <= 4'h0;
            end else if (shift_en) begin
               if (gi == ADDR_NIBBLES - 1)
                  shift_reg[gi*4 +: 4] <= nibble;
               else
                  shift_reg[gi*4 +: 4] <= shift_reg[(gi+1)*4 +: 4];
            end
         end
      end
   endgenerate

   always_ff @(posedge i_clk) begin
      if (i_reset || clear || done)
         count_reg <= 3'd0;
      else if (shift_en)
         count_reg <= count_reg + 3'd1;
   end

   // The result is presented combinationally alongside the final nibble so
   // the owning pointer can load on the same edge.
   assign done  = shift_en && !clear && (count_reg == 3'(ADDR_NIBBLES - 1));
   assign value = {nibble, shift_reg[ADDR_W-1:4]};

endmodule

// File: rtl/saturn_bus_target.sv
// ---------------------------------------------------------------------------
// saturn_bus_target
// Nibble-serial bus target with PC and DP pointers. Command nibbles pick an
// operation; data nibbles then read memory at PC/DP, write memory at DP, or
// assemble a new 20-bit pointer value.
// Ports:
//   i_clk   : system clock, rising edge
//   i_reset : synchronous, active-high reset
//   bus     : saturn_bus_target_if.slave (bus strobe/nibbles, memory port,
//             command error pulse, debug pointers)
// ---------------------------------------------------------------------------
module saturn_bus_target
   import saturn_bus_pkg::*;
(
   input  logic                 i_clk,
   input  logic                 i_reset,
   saturn_bus_target_if.slave   bus
);

   state_e            state_reg, state_next;
   logic [ADDR_W-1:0] pc_reg, pc_next;
   logic [ADDR_W-1:0] dp_reg, dp_next;
   logic              load_dp_reg, load_dp_next;      // LOAD_ADDR target: 1 = DP
   logic              read_pending_reg, read_pending_next;
   logic              cmd_error_reg, cmd_error_next;
   logic [3:0]        bus_nibble_reg;

   logic              cmd_strobe;
   logic              data_strobe;
   logic              shift_en;
   logic              shift_done;
   logic [ADDR_W-1:0] shift_value;
   cmd_e              code;

   assign cmd_strobe  = bus.i_bus_clk_en && !bus.i_bus_is_data;
   assign data_strobe = bus.i_bus_clk_en &&  bus.i_bus_is_data;
   assign shift_en    = data_strobe && (state_reg == ST_LOAD_ADDR);
   assign code        = cmd_e'(bus.i_bus_nibble);

   saturn_bus_addr_shift u_addr_shift (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .clear    (cmd_strobe),
      .shift_en (shift_en),
      .nibble   (bus.i_bus_nibble),
      .done     (shift_done),
      .value    (shift_value)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_reg        <= ST_IDLE;
         pc_reg           <= '0;
         dp_reg           <= '0;
         load_dp_reg      <= 1'b0;
         read_pending_reg <= 1'b0;
         cmd_error_reg    <= 1'b0;
         bus_nibble_reg   <= 4'h0;
      end else begin
         state_reg        <= state_next;
         pc_reg           <= pc_next;
         dp_reg           <= dp_next;
         load_dp_reg      <= load_dp_next;
         read_pending_reg <= read_pending_next;
         cmd_error_reg    <= cmd_error_next;
         // Memory answers one cycle after the address, so capture the
         // read data on the edge after the read strobe.
         if (read_pending_reg)
            bus_nibble_reg <= bus.i_mem_rdata;
      end
   end

   always_comb begin
      state_next        = state_reg;
      pc_next           = pc_reg;
      dp_next           = dp_reg;
      load_dp_next      = load_dp_reg;
      read_pending_next = 1'b0;
      cmd_error_next    = 1'b0;

      if (cmd_strobe) begin
         // Any command arriving mid-load aborts the load; the load can
         // only be pending here since completion returns to idle.
         cmd_error_next = !cmd_is_legal(bus.i_bus_nibble) ||
                          (state_reg == ST_LOAD_ADDR);
         state_next     = cmd_next_state(bus.i_bus_nibble);
         case (code)
            CMD_RESET: begin
               pc_next = '0;
               dp_next = '0;
            end
            CMD_LOAD_PC: load_dp_next = 1'b0;
            CMD_LOAD_DP: load_dp_next = 1'b1;
            default: ;
         endcase
      end else if (data_strobe) begin
         case (state_reg)
            ST_READ_PC: begin
               pc_next           = pc_reg + 1'b1;
               read_pending_next = 1'b1;
            end
            ST_READ_DP: begin
               dp_next           = dp_reg + 1'b1;
               read_pending_next = 1'b1;
            end
            ST_WRITE_DP: dp_next = dp_reg + 1'b1;
            ST_LOAD_ADDR: begin
               if (shift_done) begin
                  state_next = ST_IDLE;
                  if (load_dp_reg)
                     dp_next = shift_value;
                  else
                     pc_next = shift_value;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.o_mem_addr   = (state_reg == ST_READ_PC) ? pc_reg : dp_reg;
   assign bus.o_mem_we     = data_strobe && (state_reg == ST_WRITE_DP) && !i_reset;
   assign bus.o_mem_wdata  = bus.o_mem_we ? bus.i_bus_nibble : 4'h0;
   assign bus.o_bus_nibble = bus_nibble_reg;
   assign bus.o_cmd_error  = cmd_error_reg;
   assign bus.o_pc_ptr     = pc_reg;
   assign bus.o_dp_ptr     = dp_reg;

endmodule

// File: tb/tb_saturn_bus_target.sv
// ---------------------------------------------------------------------------
// tb_saturn_bus_target
// Self-checking bench for saturn_bus_target: directed scenarios followed by
// randomized bus traffic, compared every cycle against a transaction-level
// model of the target. Memory returns address[3:0] with one cycle latency.
// ---------------------------------------------------------------------------
module tb_saturn_bus_target;

   localparam int M_IDLE = 0;
   localparam int M_RDPC = 1;
   localparam int M_RDDP = 2;
   localparam int M_LOAD = 3;
   localparam int M_WR   = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   saturn_bus_target_if bus_if ();

   saturn_bus_target dut (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (bus_if.slave)
   );

   // Memory: one-cycle synchronous read, content = low nibble of address.
   always @(posedge clk) bus_if.i_mem_rdata <= bus_if.o_mem_addr[3:0];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int last_cyc;
   bit checking = 0;

   // Model state
   int          m_mode = M_IDLE;
   logic [19:0] m_pc = '0, m_dp = '0;
   bit          m_target_dp = 0;
   logic [3:0]  m_nibs[$];
   bit          m_rd_valid = 0;
   logic [19:0] m_rd_addr = '0;
   logic [3:0]  m_exp_nibble = 4'h0;
   bit          m_exp_err = 0;

   logic [3:0]  hist [int];
   logic [23:0] wlog [$];

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // Transaction-level model, advanced at each rising edge.
   always @(posedge clk) begin
      logic [19:0] val;
      bit err;
      cyc = cyc + 1;
      if (rst) begin
         m_mode = M_IDLE; m_pc = '0; m_dp = '0; m_target_dp = 0;
         m_nibs.delete(); m_rd_valid = 0; m_exp_nibble = 4'h0; m_exp_err = 0;
      end else begin
         err = 0;
         if (m_rd_valid) m_exp_nibble = m_rd_addr[3:0];
         m_rd_valid = 0;
         if (bus_if.i_bus_clk_en && !bus_if.i_bus_is_data) begin
            if (m_mode == M_LOAD) err = 1;
            m_nibs.delete();
            case (bus_if.i_bus_nibble)
               4'h0: m_mode = M_IDLE;
               4'h2: m_mode = M_RDPC;
               4'h3: m_mode = M_RDDP;
               4'h4: begin m_mode = M_LOAD; m_target_dp = 0; end
               4'h5: begin m_mode = M_LOAD; m_target_dp = 1; end
               4'h6: m_mode = M_WR;
               4'h8: begin m_mode = M_IDLE; m_pc = '0; m_dp = '0; end
               default: begin m_mode = M_IDLE; err = 1; end
            endcase
         end else if (bus_if.i_bus_clk_en) begin
            case (m_mode)
               M_RDPC: begin m_rd_valid = 1; m_rd_addr = m_pc; m_pc = m_pc + 20'd1; end
               M_RDDP: begin m_rd_valid = 1; m_rd_addr = m_dp; m_dp = m_dp + 20'd1; end
               M_WR:   m_dp = m_dp + 20'd1;
               M_LOAD: begin
                  m_nibs.push_back(bus_if.i_bus_nibble);
                  if (m_nibs.size() == 5) begin
                     val = '0;
                     for (int i = 0; i < 5; i++) val = val + (20'(m_nibs[i]) << (4 * i));
                     if (m_target_dp) m_dp = val; else m_pc = val;
                     m_nibs.delete();
                     m_mode = M_IDLE;
                  end
               end
               default: ;
            endcase
         end
         m_exp_err = err;
      end
   end

   // Per-cycle comparison, mid-cycle.
   always @(negedge clk) begin
      logic [19:0] exp_addr;
      logic        exp_we;
      if (checking) begin
         exp_addr = (m_mode == M_RDPC) ? m_pc : m_dp;
         exp_we   = bus_if.i_bus_clk_en && bus_if.i_bus_is_data && (m_mode == M_WR) && !rst;
         check("mem_addr", 32'(bus_if.o_mem_addr), 32'(exp_addr));
         check("mem_we", 32'(bus_if.o_mem_we), 32'(exp_we));
         if (exp_we) check("mem_wdata", 32'(bus_if.o_mem_wdata), 32'(bus_if.i_bus_nibble));
         check("pc_ptr", 32'(bus_if.o_pc_ptr), 32'(m_pc));
         check("dp_ptr", 32'(bus_if.o_dp_ptr), 32'(m_dp));
         check("bus_nibble", 32'(bus_if.o_bus_nibble), 32'(m_exp_nibble));
         check("cmd_error", 32'(bus_if.o_cmd_error), 32'(m_exp_err));
         hist[cyc] = bus_if.o_bus_nibble;
         if (bus_if.o_mem_we) wlog.push_back({bus_if.o_mem_addr, bus_if.o_mem_wdata});
      end
   end

   task automatic xfer(input logic is_data, input logic [3:0] nib);
      bus_if.i_bus_clk_en  = 1'b1;
      bus_if.i_bus_is_data = is_data;
      bus_if.i_bus_nibble  = nib;
      last_cyc = cyc;
      $display("[%0t] cyc %0d %s nibble=%h", $time, cyc, is_data ? "data" : "cmd ", nib);
      @(posedge clk); #1;
      bus_if.i_bus_clk_en = 1'b0;
   endtask

   task automatic idle(input int n);
      bus_if.i_bus_clk_en = 1'b0;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic do_reset(input bit with_strobe);
      rst = 1'b1;
      if (with_strobe) begin
         bus_if.i_bus_clk_en  = 1'b1;
         bus_if.i_bus_is_data = 1'($urandom_range(0, 1));
         bus_if.i_bus_nibble  = 4'($urandom_range(0, 15));
      end
      $display("[%0t] cyc %0d reset strobe=%0d", $time, cyc, with_strobe);
      @(posedge clk); #1;
      rst = 1'b0;
      bus_if.i_bus_clk_en = 1'b0;
   endtask

   task automatic load_ptr(input logic [3:0] cmd, input logic [19:0] v);
      xfer(1'b0, cmd);
      for (int i = 0; i < 5; i++) xfer(1'b1, v[i*4 +: 4]);
   endtask

   initial begin
      int n0, w0, r;
      logic [3:0] codes [8];
      bus_if.i_bus_clk_en  = 1'b0;
      bus_if.i_bus_is_data = 1'b0;
      bus_if.i_bus_nibble  = 4'h0;

      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      checking = 1;
      @(negedge clk);
      check("rst_pc", 32'(bus_if.o_pc_ptr), 32'h0);
      check("rst_dp", 32'(bus_if.o_dp_ptr), 32'h0);
      check("rst_nibble", 32'(bus_if.o_bus_nibble), 32'h0);
      check("rst_err", 32'(bus_if.o_cmd_error), 32'h0);
      @(posedge clk); #1;

      // LOAD_PC 0x12345
      load_ptr(4'h4, 20'h12345);
      @(negedge clk);
      check("load_pc", 32'(bus_if.o_pc_ptr), 32'h12345);
      check("load_pc_err", 32'(bus_if.o_cmd_error), 32'h0);
      @(posedge clk); #1;
      w0 = wlog.size();
      xfer(1'b1, 4'h9);   // idle data strobe: ignored
      @(negedge clk);
      check("idle_data_pc", 32'(bus_if.o_pc_ptr), 32'h12345);
      check("idle_data_dp", 32'(bus_if.o_dp_ptr), 32'h0);
      check("idle_data_nowr", 32'(wlog.size()), 32'(w0));
      @(posedge clk); #1;

      // PC_READ x3, back-to-back
      xfer(1'b0, 4'h2);
      xfer(1'b1, 4'h0); n0 = last_cyc;
      xfer(1'b1, 4'h0);
      xfer(1'b1, 4'h0);
      idle(3);
      check("rd0", 32'(hist[n0+2]), 32'h5);
      check("rd1", 32'(hist[n0+3]), 32'h6);
      check("rd2", 32'(hist[n0+4]), 32'h7);
      check("rd_pc", 32'(bus_if.o_pc_ptr), 32'h12348);

      // DP wrap on write
      load_ptr(4'h5, 20'hFFFFF);
      xfer(1'b0, 4'h6);
      w0 = wlog.size();
      xfer(1'b1, 4'hA);
      xfer(1'b1, 4'hB);
      idle(1);
      check("wr_count", 32'(wlog.size() - w0), 32'd2);
      if (wlog.size() - w0 == 2) begin
         check("wr0", 32'(wlog[w0]), 32'hFFFFFA);
         check("wr1", 32'(wlog[w0+1]), 32'h00000B);
      end
      check("wr_dp", 32'(bus_if.o_dp_ptr), 32'h00001);

      // Abort a LOAD_DP with PC_READ
      xfer(1'b0, 4'h5);
      xfer(1'b1, 4'h7);
      xfer(1'b1, 4'h7);
      xfer(1'b0, 4'h2);
      @(negedge clk);
      check("abort_err", 32'(bus_if.o_cmd_error), 32'h1);
      check("abort_dp", 32'(bus_if.o_dp_ptr), 32'h00001);
      check("abort_state", 32'(bus_if.o_mem_addr), 32'h12348);
      @(posedge clk); #1;
      @(negedge clk);
      check("abort_err_1cyc", 32'(bus_if.o_cmd_error), 32'h0);
      @(posedge clk); #1;

      // Illegal command 0xF
      xfer(1'b0, 4'hF);
      @(negedge clk);
      check("illegal_err", 32'(bus_if.o_cmd_error), 32'h1);
      @(posedge clk); #1;
      w0 = wlog.size();
      xfer(1'b1, 4'h3);
      @(negedge clk);
      check("illegal_err_1cyc", 32'(bus_if.o_cmd_error), 32'h0);
      check("illegal_nowr", 32'(wlog.size()), 32'(w0));
      check("illegal_pc", 32'(bus_if.o_pc_ptr), 32'h12348);
      check("illegal_dp", 32'(bus_if.o_dp_ptr), 32'h00001);
      @(posedge clk); #1;

      // Reset mid-LOAD_PC, then a fresh load
      xfer(1'b0, 4'h4);
      xfer(1'b1, 4'h1);
      xfer(1'b1, 4'h2);
      xfer(1'b1, 4'h3);
      do_reset(0);
      @(negedge clk);
      check("midrst_pc", 32'(bus_if.o_pc_ptr), 32'h0);
      @(posedge clk); #1;
      load_ptr(4'h4, 20'hABCDE);
      @(negedge clk);
      check("reload_pc", 32'(bus_if.o_pc_ptr), 32'hABCDE);
      @(posedge clk); #1;

      // RESET command
      xfer(1'b0, 4'h8);
      @(negedge clk);
      check("cmdrst_pc", 32'(bus_if.o_pc_ptr), 32'h0);
      @(posedge clk); #1;

      // Randomized traffic
      codes[0] = 4'h0; codes[1] = 4'h2; codes[2] = 4'h3; codes[3] = 4'h4;
      codes[4] = 4'h5; codes[5] = 4'h6; codes[6] = 4'h8; codes[7] = 4'h0;
      for (int i = 0; i < 600; i++) begin
         r = $urandom_range(0, 99);
         if (r < 2) begin
            do_reset(1'($urandom_range(0, 1)));
         end else if (r < 25) begin
            if ($urandom_range(0, 7) == 0) xfer(1'b0, 4'($urandom_range(0, 15)));
            else xfer(1'b0, codes[$urandom_range(0, 6)]);
         end else if (r < 85) begin
            xfer(1'b1, 4'($urandom_range(0, 15)));
         end else begin
            idle(1);
         end
      end
      idle(3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
